// File: rtl/prbs_checker.sv
// Receive-side PRBS-15 (x^15+x^14+1) checker. It seeds a local LFSR from the incoming stream,
// counts bit errors, drops lock after LossThresh consecutive errored words and re-seeds by itself.
module prbs_checker #(
   parameter int BusWidth   = 8,
   parameter int ErrWidth   = 16,
   parameter int LossThresh = 4,
   parameter int RsWidth    = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [BusWidth-1:0] InData,
   input  logic                Start,
   input  logic                Clear,
   output logic                Locked,
   output logic                BitErr,
   output logic [ErrWidth-1:0] ErrCount,
   output logic [RsWidth-1:0]  ResyncCount
);

   localparam int         EW         = $clog2(BusWidth + 1);
   localparam int         SEED_WORDS = (BusWidth == 8) ? 2 : 1;
   localparam logic       SEED_LAST  = 1'(SEED_WORDS - 1);
   localparam logic [3:0] THRESH     = 4'(LossThresh);

   typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;

   state_t              state;
   logic [14:0]         lfsr;
   logic                seed_cnt;
   logic [3:0]          consec;
   logic [BusWidth-1:0] exp_word;
   logic [EW-1:0]       nerr;

   // Shift a word into a 15-bit history, MSB (earliest bit) first; newest bit lands in s[0].
   function automatic logic [14:0] seed_shift(input logic [14:0] s, input logic [BusWidth-1:0] w);
      logic [14:0] t;
      t = s;
      for (int i = BusWidth - 1; i >= 0; i--) t = {t[13:0], w[i]};
      return t;
   endfunction

   function automatic logic [BusWidth-1:0] lfsr_word(input logic [14:0] s);
      logic [14:0]         t;
      logic [BusWidth-1:0] w;
      t = s;
      w = '0;
      for (int i = BusWidth - 1; i >= 0; i--) begin
         w[i] = t[14] ^ t[13];
         t    = {t[13:0], w[i]};
      end
      return w;
   endfunction

   function automatic logic [EW-1:0] popcount(input logic [BusWidth-1:0] x);
      logic [EW-1:0] n;
      n = '0;
      for (int i = 0; i < BusWidth; i++) n = n + EW'(x[i]);
      return n;
   endfunction

   function automatic logic [ErrWidth-1:0] sat_add(input logic [ErrWidth-1:0] a,
                                                   input logic [EW-1:0]       b);
      logic [ErrWidth+EW-1:0] sum;
      sum = {{EW{1'b0}}, a} + {{ErrWidth{1'b0}}, b};
      if (sum[ErrWidth+EW-1:ErrWidth] != '0) return '1;
      return sum[ErrWidth-1:0];
   endfunction

   assign exp_word = lfsr_word(lfsr);
   assign nerr     = popcount(InData ^ exp_word);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= IDLE;
         lfsr        <= '0;
         seed_cnt    <= 1'b0;
         consec      <= '0;
         Locked      <= 1'b0;
         BitErr      <= 1'b0;
         ErrCount    <= '0;
         ResyncCount <= '0;
      end else begin
         BitErr <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  state    <= SEED;
                  seed_cnt <= 1'b0;
               end
            end
            SEED: begin
               lfsr <= seed_shift(lfsr, InData);
               if (seed_cnt == SEED_LAST) begin
                  state  <= CHECK;
                  Locked <= 1'b1;
                  consec <= '0;
               end else begin
                  seed_cnt <= seed_cnt + 1'b1;
               end
            end
            CHECK: begin
               // Advancing BusWidth steps equals shifting in the LFSR's own output bits.
               lfsr <= seed_shift(lfsr, exp_word);
               if (nerr != '0) begin
                  BitErr   <= 1'b1;
                  ErrCount <= sat_add(ErrCount, nerr);
                  if (consec + 4'd1 == THRESH) begin
                     state    <= SEED;
                     seed_cnt <= 1'b0;
                     Locked   <= 1'b0;
                     consec   <= '0;
                     if (ResyncCount != '1) ResyncCount <= ResyncCount + 1'b1;
                  end else begin
                     consec <= consec + 4'd1;
                  end
               end else begin
                  consec <= '0;
               end
            end
            default: state <= IDLE;
         endcase
         if (Clear) begin
            ErrCount    <= '0;
            ResyncCount <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboarded bench for prbs_checker: a 16-bit and a 4-bit ErrCount instance share one stimulus stream.
module tb_prbs_checker;

   logic       CLK = 1'b0;
   logic       RST, Start, Clear;
   logic [7:0] InData;
   logic       lk_a, be_a, lk_b, be_b;
   logic [15:0] ec_a;
   logic [3:0]  ec_b;
   logic [7:0]  rs_a, rs_b;

   always #5 CLK = ~CLK;

   prbs_checker #(.BusWidth(8), .ErrWidth(16), .LossThresh(4), .RsWidth(8)) dut_a (
      .CLK(CLK), .RST(RST), .InData(InData), .Start(Start), .Clear(Clear),
      .Locked(lk_a), .BitErr(be_a), .ErrCount(ec_a), .ResyncCount(rs_a));

   prbs_checker #(.BusWidth(8), .ErrWidth(4), .LossThresh(4), .RsWidth(8)) dut_b (
      .CLK(CLK), .RST(RST), .InData(InData), .Start(Start), .Clear(Clear),
      .Locked(lk_b), .BitErr(be_b), .ErrCount(ec_b), .ResyncCount(rs_b));

   typedef struct {
      logic lk;
      logic be;
      int   tot;
      int   rs;
   } exp_t;

   exp_t        sbq[$];
   int          nvec = 0;
   int          nmis = 0;
   int          tot  = 0;
   int          rs   = 0;
   logic [14:0] g    = 15'h7FFF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Reference PRBS-15 source, earliest bit in the word MSB.
   task automatic next_word(output logic [7:0] w);
      logic nb;
      for (int i = 7; i >= 0; i--) begin
         nb   = g[14] ^ g[13];
         g    = {g[13:0], nb};
         w[i] = nb;
      end
   endtask

   task automatic send(input logic [7:0] w, input bit st, input bit clr,
                       input bit lk, input bit be, input int e_add, input int rs_add);
      exp_t e;
      @(negedge CLK);
      RST    = 1'b1;
      InData = w;
      Start  = st;
      Clear  = clr;
      if (clr) begin
         tot = 0;
         rs  = 0;
      end else begin
         tot += e_add;
         rs  += rs_add;
      end
      e.lk = lk; e.be = be; e.tot = tot; e.rs = rs;
      sbq.push_back(e);
   endtask

   task automatic rst_cycle(input logic [7:0] w, input bit st);
      exp_t e;
      @(negedge CLK);
      RST    = 1'b0;
      InData = w;
      Start  = st;
      Clear  = 1'b0;
      tot    = 0;
      rs     = 0;
      e.lk = 1'b0; e.be = 1'b0; e.tot = 0; e.rs = 0;
      sbq.push_back(e);
   endtask

   always @(posedge CLK) begin
      #1;
      if (sbq.size() > 0) begin : pop
         exp_t e;
         e = sbq.pop_front();
         chk("locked_a", 32'(lk_a), 32'(e.lk));
         chk("biterr_a", 32'(be_a), 32'(e.be));
         chk("errcnt_a", 32'(ec_a), sat(e.tot, 65535));
         chk("resync_a", 32'(rs_a), sat(e.rs, 255));
         chk("locked_b", 32'(lk_b), 32'(e.lk));
         chk("biterr_b", 32'(be_b), 32'(e.be));
         chk("errcnt_b", 32'(ec_b), sat(e.tot, 15));
         chk("resync_b", 32'(rs_b), sat(e.rs, 255));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] w;
      RST = 1'b0; Start = 1'b0; Clear = 1'b0; InData = '0;

      repeat (3) rst_cycle(8'($urandom), 1'b1);

      // Clean lock: Start word ignored, two seed words, Locked after the second.
      send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      repeat (1000) begin
         next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      end

      // Single bit flip.
      next_word(w); send(w ^ 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

      // Burst of four fully errored words forces loss of lock, then automatic re-seed.
      for (int i = 0; i < 4; i++) begin
         next_word(w); send(w ^ 8'hFF, 1'b0, 1'b0, (i < 3), 1'b1, 8, (i == 3) ? 1 : 0);
      end
      next_word(w); send(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      repeat (20) begin
         next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      end
      next_word(w); send(w, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

      // Reset mid-CHECK, then the checker must wait in IDLE for a new Start.
      next_word(w); rst_cycle(w, 1'b0);
      repeat (3) begin
         next_word(w); send(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      repeat (5) begin
         next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      end

      // Saturation of the 4-bit counter, then Clear on the word that also trips loss of lock.
      repeat (3) begin
         next_word(w); send(w ^ 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8, 0);
      end
      next_word(w); send(w ^ 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1);
      next_word(w); send(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      repeat (5) begin
         next_word(w); send(w, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      end

      repeat (2) @(posedge CLK);
      #2;
      chk("drain", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
